// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encoding,
// opcode/funct values, ALU operation codes and datapath select codes.
package mips_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam state_t IDLE   = 4'd0;
    localparam state_t FETCH  = 4'd1;
    localparam state_t DECODE = 4'd2;
    localparam state_t MEMADR = 4'd3;
    localparam state_t MEMRD  = 4'd4;
    localparam state_t MEMWB  = 4'd5;
    localparam state_t MEMWR  = 4'd6;
    localparam state_t EXEC   = 4'd7;
    localparam state_t ALUWB  = 4'd8;
    localparam state_t BRANCH = 4'd9;
    localparam state_t ADDIEX = 4'd10;
    localparam state_t ADDIWB = 4'd11;
    localparam state_t JUMP   = 4'd12;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    // States that sit on the memory handshake and may time out.
    function automatic logic is_wait_state(input state_t s);
        return (s == FETCH) || (s == MEMRD) || (s == MEMWR);
    endfunction

endpackage

// File: rtl/mips_mc_ctrl_alu_dec.sv
// R-type funct decoder: maps funct to an ALU operation and flags unsupported
// funct values. Also used by the standalone ALU bench.
module mips_alu_dec (
    input  logic [5:0] funct,
    output logic [3:0] aluctr,
    output logic       legal
);
    import mips_ctrl_pkg::*;

    always_comb begin
        aluctr = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  aluctr = ALU_ADD;
            FN_SUB:  aluctr = ALU_SUB;
            FN_AND:  aluctr = ALU_AND;
            FN_OR:   aluctr = ALU_OR;
            FN_SLT:  aluctr = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM sequencing a shared ALU and unified memory.
// Optional performance counters are built when CTRL_PERF_EN is defined.
module mips_mc_ctrl #(
    parameter int WAIT_LIMIT = 0,
    parameter int CNT_W      = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [5:0]       OpCode,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUCtr,
    output logic [1:0]       PCSrc,
    output logic             PCEn,
    output logic             InstrDone,
    output logic             Illegal,
    output logic             BusErr,
    output logic [CNT_W-1:0] InstrCount,
    output logic [CNT_W-1:0] CycleCount
);
    import mips_ctrl_pkg::*;

    state_t     state, next_state;
    logic [3:0] funct_ctr;
    logic       funct_legal;
    logic       op_legal;
    logic       timeout;

    mips_alu_dec u_alu_dec (
        .funct  (Funct),
        .aluctr (funct_ctr),
        .legal  (funct_legal)
    );

    // Timeout fires on the WAIT_LIMIT-th consecutive not-ready cycle; a ready
    // in that same cycle masks it because the count only covers MemReady=0.
    generate
        if (WAIT_LIMIT > 0) begin : g_timeout
            localparam int WW = $clog2(WAIT_LIMIT + 1);
            logic [WW-1:0] wait_cnt;
            logic          waiting;

            assign waiting = is_wait_state(state);
            assign timeout = waiting && !MemReady && (wait_cnt == WW'(WAIT_LIMIT - 1));

            always_ff @(posedge Clk or posedge Rst) begin
                if (Rst)
                    wait_cnt <= '0;
                else if (waiting && !MemReady && !timeout)
                    wait_cnt <= wait_cnt + WW'(1);
                else
                    wait_cnt <= '0;
            end
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    always_comb begin
        op_legal = 1'b1;
        case (OpCode)
            OP_RTYPE:                             op_legal = funct_legal;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J:  op_legal = 1'b1;
            default:                              op_legal = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   next_state = FETCH;
            FETCH:  if (MemReady) next_state = DECODE;
            DECODE: begin
                if (!op_legal)
                    next_state = FETCH;
                else begin
                    case (OpCode)
                        OP_LW, OP_SW: next_state = MEMADR;
                        OP_BEQ:       next_state = BRANCH;
                        OP_ADDI:      next_state = ADDIEX;
                        OP_J:         next_state = JUMP;
                        default:      next_state = EXEC;
                    endcase
                end
            end
            MEMADR: next_state = (OpCode == OP_LW) ? MEMRD : MEMWR;
            MEMRD: begin
                if (MemReady)
                    next_state = MEMWB;
                else if (timeout)
                    next_state = FETCH;
            end
            MEMWR:  if (MemReady || timeout) next_state = FETCH;
            EXEC:   next_state = ALUWB;
            ADDIEX: next_state = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: next_state = FETCH;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegDst    = 1'b0;
        MemToReg  = 1'b0;
        RegWrite  = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ALUCtr    = ALU_AND;
        PCSrc     = PC_ALU;
        PCEn      = 1'b0;
        InstrDone = 1'b0;
        Illegal   = 1'b0;
        BusErr    = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                ALUCtr  = ALU_ADD;
                IRWrite = MemReady;
                PCEn    = MemReady;
                BusErr  = timeout;
            end
            DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                ALUCtr  = ALU_ADD;
                Illegal = !op_legal;
            end
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUCtr  = ALU_ADD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                BusErr  = timeout;
            end
            MEMWB: begin
                RegWrite  = 1'b1;
                MemToReg  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWR: begin
                MemWrite  = 1'b1;
                IorD      = 1'b1;
                InstrDone = MemReady;
                BusErr    = timeout;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUCtr  = funct_ctr;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                RegDst    = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 1'b1;
                ALUCtr    = ALU_SUB;
                PCSrc     = PC_ALUOUT;
                PCEn      = Zero;
                InstrDone = 1'b1;
            end
            ADDIWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            JUMP: begin
                PCSrc     = PC_JUMP;
                PCEn      = 1'b1;
                InstrDone = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] instr_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            instr_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (InstrDone)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign InstrCount = instr_cnt;
    assign CycleCount = cycle_cnt;
`else
    assign InstrCount = '0;
    assign CycleCount = '0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: an instruction-level model queues the
// expected control word per cycle and a negedge monitor compares it.
module tb_mips_mc_ctrl;

    localparam int WAIT_LIMIT = 4;
    localparam int CNT_W      = 32;
`ifdef CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic [5:0]       OpCode = '0;
    logic [5:0]       Funct = '0;
    logic             Zero = 1'b0;
    logic             MemReady = 1'b0;
    logic             IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
    logic [1:0]       ALUSrcB, PCSrc;
    logic [3:0]       ALUCtr;
    logic             PCEn, InstrDone, Illegal, BusErr;
    logic [CNT_W-1:0] InstrCount, CycleCount;

    mips_mc_ctrl #(.WAIT_LIMIT(WAIT_LIMIT), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtr(ALUCtr), .PCSrc(PCSrc),
        .PCEn(PCEn), .InstrDone(InstrDone), .Illegal(Illegal), .BusErr(BusErr),
        .InstrCount(InstrCount), .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb;
        logic [3:0] aluctr;
        logic [1:0] pcsrc;
        logic       pcen, instrdone, illegal, buserr;
    } ctl_t;

    typedef struct {
        ctl_t  val;
        ctl_t  care;
        bit    idle;
        string tag;
    } exp_t;

    exp_t       sbq[$];
    int         vectors = 0;
    int         miscompares = 0;
    logic [5:0] irOp = '0;
    logic [5:0] irFn = '0;
    logic [5:0] fnList [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    function automatic ctl_t sampleCtl();
        ctl_t c;
        c.iord = IorD; c.memread = MemRead; c.memwrite = MemWrite; c.irwrite = IRWrite;
        c.regdst = RegDst; c.memtoreg = MemToReg; c.regwrite = RegWrite; c.alusrca = ALUSrcA;
        c.alusrcb = ALUSrcB; c.aluctr = ALUCtr; c.pcsrc = PCSrc; c.pcen = PCEn;
        c.instrdone = InstrDone; c.illegal = Illegal; c.buserr = BusErr;
        return c;
    endfunction

    // Enables and pulses must be exactly right every cycle; selects only where defined.
    function automatic ctl_t baseCare();
        ctl_t c = '0;
        c.memread = 1'b1; c.memwrite = 1'b1; c.irwrite = 1'b1; c.regwrite = 1'b1;
        c.pcen = 1'b1; c.instrdone = 1'b1; c.illegal = 1'b1; c.buserr = 1'b1;
        return c;
    endfunction

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic bit functOk(input logic [5:0] fn);
        return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    endfunction

    function automatic bit instrOk(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) return functOk(fn);
        return op inside {6'h02, 6'h04, 6'h08, 6'h23, 6'h2B};
    endfunction

    function automatic logic [3:0] aluFor(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic checkOutput(input string name, input ctl_t act, input ctl_t exp, input ctl_t care);
        vectors++;
        if (((act ^ exp) & care) != '0) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (care %h) at %0t", name, act, exp, care, $time);
        end
    endtask

    task automatic checkCount(input string name, input logic [CNT_W-1:0] act, input int exp);
        vectors++;
        if (act != CNT_W'(exp)) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input string tag, input logic mr, input logic z, input ctl_t v, input ctl_t c);
        exp_t e;
        @(posedge Clk);
        #1;
        MemReady = mr;
        Zero     = z;
        OpCode   = irOp;
        Funct    = irFn;
        e.val = v; e.care = c; e.idle = 1'b0; e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic pushIdle();
        exp_t e;
        e.val = '0; e.care = '1; e.idle = 1'b1; e.tag = "IDLE";
        sbq.push_back(e);
    endtask

    task automatic doReset();
        @(negedge Clk);
        #1;
        Rst = 1'b1;
        MemReady = 1'b0;
        #1;
        checkOutput("reset", sampleCtl(), '0, '1);
        checkCount("InstrCount-reset", InstrCount, 0);
        checkCount("CycleCount-reset", CycleCount, 0);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        pushIdle();
    endtask

    task automatic doFetch(input int stalls);
        ctl_t v = '0;
        ctl_t c = baseCare();
        c.iord = 1'b1; c.alusrca = 1'b1; c.alusrcb = '1; c.aluctr = '1; c.pcsrc = '1;
        v.memread = 1'b1; v.alusrcb = 2'b01; v.aluctr = 4'b0010;
        for (int k = 1; k <= stalls; k++) begin
            v.buserr = (k % WAIT_LIMIT) == 0;
            step("FETCH-wait", 1'b0, rbit(), v, c);
        end
        v.buserr = 1'b0; v.irwrite = 1'b1; v.pcen = 1'b1;
        step("FETCH", 1'b1, rbit(), v, c);
    endtask

    task automatic aluStep(input string tag, input logic a, input logic [1:0] b,
                           input logic [3:0] op, input logic ill);
        ctl_t v = '0;
        ctl_t c = baseCare();
        c.alusrca = 1'b1; c.alusrcb = '1; c.aluctr = '1;
        v.alusrca = a; v.alusrcb = b; v.aluctr = op; v.illegal = ill;
        step(tag, rbit(), rbit(), v, c);
    endtask

    task automatic wbStep(input string tag, input logic rd, input logic m2r);
        ctl_t v = '0;
        ctl_t c = baseCare();
        c.regdst = 1'b1; c.memtoreg = 1'b1;
        v.regwrite = 1'b1; v.regdst = rd; v.memtoreg = m2r; v.instrdone = 1'b1;
        step(tag, rbit(), rbit(), v, c);
    endtask

    task automatic memAccess(input bit isWrite, input int stalls);
        ctl_t v = '0;
        ctl_t c = baseCare();
        c.iord = 1'b1;
        v.iord = 1'b1; v.memwrite = isWrite; v.memread = !isWrite;
        for (int k = 1; k <= stalls; k++) begin
            if (k == WAIT_LIMIT) begin
                v.buserr = 1'b1;
                step("MEM-timeout", 1'b0, rbit(), v, c);
                return;
            end
            step("MEM-wait", 1'b0, rbit(), v, c);
        end
        v.instrdone = isWrite;
        step("MEM", 1'b1, rbit(), v, c);
        if (!isWrite) wbStep("MEMWB", 1'b0, 1'b1);
    endtask

    // One instruction: sf fetch stalls, sm memory stalls, zr for beq.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                                 input int sf, input int sm);
        ctl_t v = '0;
        ctl_t c = baseCare();
        doFetch(sf);
        irOp = op;
        irFn = fn;
        aluStep("DECODE", 1'b0, 2'b11, 4'b0010, !instrOk(op, fn));
        if (!instrOk(op, fn)) return;
        case (op)
            6'h23, 6'h2B: begin
                aluStep("MEMADR", 1'b1, 2'b10, 4'b0010, 1'b0);
                memAccess(op == 6'h2B, sm);
            end
            6'h00: begin
                aluStep("EXEC", 1'b1, 2'b00, aluFor(fn), 1'b0);
                wbStep("ALUWB", 1'b1, 1'b0);
            end
            6'h08: begin
                aluStep("ADDIEX", 1'b1, 2'b10, 4'b0010, 1'b0);
                wbStep("ADDIWB", 1'b0, 1'b0);
            end
            6'h04: begin
                c.alusrca = 1'b1; c.alusrcb = '1; c.aluctr = '1; c.pcsrc = '1;
                v.alusrca = 1'b1; v.aluctr = 4'b0110; v.pcsrc = 2'b01;
                v.pcen = zr; v.instrdone = 1'b1;
                step("BRANCH", rbit(), zr, v, c);
            end
            default: begin
                c.pcsrc = '1;
                v.pcsrc = 2'b10; v.pcen = 1'b1; v.instrdone = 1'b1;
                step("JUMP", rbit(), rbit(), v, c);
            end
        endcase
    endtask

    task automatic rstDuringMemWr();
        ctl_t v = '0;
        ctl_t c = baseCare();
        doFetch(0);
        irOp = 6'h2B;
        irFn = 6'($urandom);
        aluStep("DECODE", 1'b0, 2'b11, 4'b0010, 1'b0);
        aluStep("MEMADR", 1'b1, 2'b10, 4'b0010, 1'b0);
        @(posedge Clk);
        #1;
        MemReady = 1'b0;
        #1;
        c.iord = 1'b1;
        v.iord = 1'b1; v.memwrite = 1'b1;
        checkOutput("MEMWR-before-reset", sampleCtl(), v, c);
        Rst = 1'b1;
        #1;
        checkOutput("async-reset-in-MEMWR", sampleCtl(), '0, '1);
        checkCount("CycleCount-async-reset", CycleCount, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        pushIdle();
    endtask

    // Monitor: pops one expected word per cycle and tracks perf counters.
    initial begin
        exp_t e;
        int   expCyc = 0;
        int   expInstr = 0;
        forever begin
            @(negedge Clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.idle) begin
                    expCyc = 0;
                    expInstr = 0;
                end
                checkOutput(e.tag, sampleCtl(), e.val, e.care);
                checkCount("CycleCount", CycleCount, PERF ? expCyc : 0);
                checkCount("InstrCount", InstrCount, PERF ? expInstr : 0);
                expCyc++;
                if (e.val.instrdone) expInstr++;
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [5:0] op, fn;
        doReset();
        applyStimulus(6'h00, 6'h20, 1'b0, 0, 0);
        applyStimulus(6'h23, 6'h00, 1'b0, 0, 3);
        applyStimulus(6'h04, 6'h11, 1'b1, 0, 0);
        applyStimulus(6'h04, 6'h11, 1'b0, 0, 0);
        applyStimulus(6'h3F, 6'h20, 1'b0, 0, 0);
        applyStimulus(6'h00, 6'h03, 1'b0, 0, 0);
        applyStimulus(6'h02, 6'h00, 1'b0, 4, 0);
        applyStimulus(6'h02, 6'h00, 1'b0, 9, 0);
        applyStimulus(6'h2B, 6'h00, 1'b0, 3, 4);
        applyStimulus(6'h23, 6'h00, 1'b0, 0, 5);
        applyStimulus(6'h08, 6'h00, 1'b0, 1, 0);
        rstDuringMemWr();
        for (int i = 0; i < 10; i++) applyStimulus(6'h02, 6'($urandom), 1'b0, 0, 0);
        doReset();
        for (int i = 0; i < 200; i++) begin
            fn = 6'($urandom);
            case ($urandom_range(0, 7))
                0:       op = 6'h23;
                1:       op = 6'h2B;
                2:       begin op = 6'h00; fn = fnList[$urandom_range(0, 4)]; end
                3:       op = 6'h04;
                4:       op = 6'h08;
                5:       op = 6'h02;
                6:       begin
                    op = 6'($urandom);
                    while (op inside {6'h00, 6'h02, 6'h04, 6'h08, 6'h23, 6'h2B}) op = 6'($urandom);
                end
                default: begin
                    op = 6'h00;
                    while (functOk(fn)) fn = 6'($urandom);
                end
            endcase
            applyStimulus(op, fn, rbit(), $urandom_range(0, 3), $urandom_range(0, 3));
        end
        repeat (3) @(negedge Clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS core. It sequences one shared ALU, the register file and one unified instruction/data memory over 3–5 cycles per instruction.
- Decodes the opcode and funct fields from the instruction register and drives all datapath selects and enables. It waits on a memory ready handshake.
- Replaces the combinational per-instruction decoder when the core moves to a single-memory, multi-cycle datapath.

Parameters:
- WAIT_LIMIT, 0, maximum cycles to wait for MemReady before flagging a bus error; 0 disables the timeout.
- CNT_W, 32, width of the performance counters.

Ports:
- Clk  in  1  core clock; all state changes on the rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- OpCode  in  6  IR[31:26].
- Funct  in  6  IR[5:0].
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completes the current read or write this cycle.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  load the instruction register.
- RegDst  out  1  register write address select: 1 = rd, 0 = rt.
- MemToReg  out  1  register write data select: 1 = MDR, 0 = ALUOut.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = register A.
- ALUSrcB  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUCtr  out  4  ALU operation.
- PCSrc  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC load enable.
- InstrDone  out  1  one-cycle pulse when an instruction retires.
- Illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode or funct.
- BusErr  out  1  one-cycle pulse on a MemReady timeout.
- InstrCount  out  CNT_W  retired instruction count.
- CycleCount  out  CNT_W  cycles since reset.

Behaviour:
- State register only; all outputs are decoded combinationally from the state, plus MemReady and Zero.
- Rst forces IDLE, where every output is 0. IDLE goes to FETCH on the next edge.
- Reset mid-instruction aborts immediately; nothing is written while Rst is high.
- States and transitions:
  - IDLE → FETCH.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUCtr=ADD, PCSrc=00. IRWrite and PCEn are asserted only in the cycle MemReady=1, which also moves to DECODE. Otherwise stay in FETCH.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUCtr=ADD (precomputes the branch target).
    - lw (0x23) / sw (0x2B) → MEMADR.
    - R-type (0x00) with a legal funct → EXEC.
    - beq (0x04) → BRANCH.
    - addi (0x08) → ADDIEX.
    - j (0x02) → JUMP.
    - Anything else → pulse Illegal and go to FETCH; no state is modified and InstrDone is not pulsed.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Go to MEMRD for lw, MEMWR for sw.
  - MEMRD: MemRead=1, IorD=1. Hold until MemReady, then go to MEMWB.
  - MEMWB: RegWrite=1, RegDst=0, MemToReg=1, InstrDone. Go to FETCH.
  - MEMWR: MemWrite=1, IorD=1. Hold until MemReady, then pulse InstrDone and go to FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUCtr from funct. Go to ALUWB.
  - ALUWB: RegWrite=1, RegDst=1, MemToReg=0, InstrDone. Go to FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01, PCEn=Zero, InstrDone. Go to FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ADD. Go to ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemToReg=0, InstrDone. Go to FETCH.
  - JUMP: PCSrc=10, PCEn=1, InstrDone. Go to FETCH.
- Latency with MemReady tied high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
- Funct map:
  - 0x20 ADD → 0010
  - 0x22 SUB → 0110
  - 0x24 AND → 0000
  - 0x25 OR → 0001
  - 0x2A SLT → 0111
- Any other funct is illegal.
- Timeout (WAIT_LIMIT>0):
  - A wait counter counts consecutive cycles with MemReady=0 in FETCH, MEMRD or MEMWR, and clears on state exit.
  - When it reaches WAIT_LIMIT: pulse BusErr and abort to FETCH, with no IRWrite, PCEn or RegWrite.
  - MemReady=1 in the same cycle as the limit wins: the access completes normally and BusErr is not pulsed.
- Outside FETCH, MEMRD and MEMWR, MemReady is ignored.

Optional Feature:
- CTRL_PERF_EN defined:
  - CycleCount increments every cycle after reset.
  - InstrCount increments on InstrDone.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Not defined: both outputs are tied to 0 and no counter flops exist.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encoding localparams: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP;
  - opcode and funct constants;
  - ALUCtr encodings;
  - ALUSrcB and PCSrc select codes.
- One sub-module, mips_alu_dec: combinational funct → {ALUCtr, legal}, shared with the existing ALU bench.

Test Plan:
- Reset release, MemReady=1, opcode 0x00, funct 0x20: IDLE → FETCH → DECODE → EXEC → ALUWB. RegWrite=1 and RegDst=1 in cycle 5 after reset release; InstrDone pulses once.
- lw (0x23) with MemReady low for 3 cycles in MEMRD: the state holds in MEMRD, MemRead=1 and IorD=1 for all 4 cycles, then MEMWB asserts RegWrite with MemToReg=1.
- beq with Zero=1, then with Zero=0: PCEn=1 with PCSrc=01 in BRANCH for the first, PCEn=0 for the second; 3 cycles each.
- Opcode 0x3F, and R-type with funct 0x03: Illegal pulses in DECODE, then FETCH; no RegWrite, MemWrite or PCEn, no InstrDone.
- WAIT_LIMIT=4 with MemReady stuck low in FETCH: BusErr pulses on the 4th wait cycle, IRWrite is never asserted, FETCH restarts. Assert Rst during MEMWR and check all outputs drop to 0 asynchronously.
- CTRL_PERF_EN defined, 10 j instructions back-to-back: InstrCount=10 and CycleCount=31 (IDLE plus 10×3).
